// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard and sequencing controller for a 5-stage ARM pipeline. It sits beside
//   the ID stage and drives every pipeline-register freeze, flush and bubble input.
//   - Detects RAW hazards and stalls or bubbles the front end.
//   - Freezes the whole pipe while the data memory is busy.
//   - Flushes IF/ID on taken branches.
//   - Lets a forwarding-mode change take effect only at a safe point.
//   - Raises a sticky error if a memory access never completes.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   fwd_mode_req          1 = forwarding requested, 0 = stall-only operation
//   src_1, src_2, two_src ID-stage source registers; two_src = src_2 is read
//   EXE_dest/_wb_en/_mem_read  EXE-stage destination, writeback, load
//   MEM_dest/_wb_en       MEM-stage destination and writeback
//   branch_taken          EXE-stage branch resolved taken
//   mem_req, mem_ready    data-memory access request / completion
//   freeze_pc, freeze_IF_ID, bubble_ID_EXE, flush_IF_ID, freeze_back
//                         pipeline-register controls (combinational decode)
//   fwd_enable            registered enable to the forwarding unit
//   mem_timeout           sticky memory-timeout error flag
//
// Optional build macro
//   PERF_CNT_EN           adds the 32-bit counters stall_cycles, flush_cycles
//                         and memwait_cycles.
//
// Parameters
//   MEM_TIMEOUT           last MEM_WAIT count that is tolerated
//   CNT_W                 wait counter width; 2**CNT_W must exceed MEM_TIMEOUT
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fwd_mode_req,
  input  logic [3:0] src_1,
  input  logic [3:0] src_2,
  input  logic       two_src,
  input  logic [3:0] EXE_dest,
  input  logic       EXE_wb_en,
  input  logic       EXE_mem_read,
  input  logic [3:0] MEM_dest,
  input  logic       MEM_wb_en,
  input  logic       branch_taken,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       freeze_pc,
  output logic       freeze_IF_ID,
  output logic       bubble_ID_EXE,
  output logic       flush_IF_ID,
  output logic       freeze_back,
  output logic       fwd_enable,
`ifdef PERF_CNT_EN
  output logic       mem_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cycles,
  output logic [31:0] memwait_cycles
`else
  output logic       mem_timeout
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  logic exe_hit;
  logic mem_hit;
  logic hazard;
  logic mem_busy;
  logic frozen;
  logic wait_expired;

  // Register-match terms; src_2 only counts when the instruction reads it.
  assign exe_hit = EXE_wb_en && ((EXE_dest == src_1) || (two_src && (EXE_dest == src_2)));
  assign mem_hit = MEM_wb_en && ((MEM_dest == src_1) || (two_src && (MEM_dest == src_2)));

  // With forwarding, only a load feeding the next instruction needs a stall.
  assign hazard = fwd_enable ? (exe_hit && EXE_mem_read) : (exe_hit || mem_hit);

  // A request that completes in the same cycle costs no wait cycle.
  assign mem_busy = (state == ST_MEM_WAIT) ||
                    ((state == ST_RUN) && mem_req && !mem_ready);

  assign frozen       = (state == ST_ERR) || mem_busy;
  assign wait_expired = (wait_cnt == CNT_W'(MEM_TIMEOUT)) && !mem_ready;

  // Control decode: freeze beats branch flush, branch flush beats hazard stall.
  // A branch held in a frozen EXE stage is flushed on the first unfrozen cycle.
  always_comb begin
    freeze_pc     = 1'b0;
    freeze_IF_ID  = 1'b0;
    bubble_ID_EXE = 1'b0;
    flush_IF_ID   = 1'b0;
    freeze_back   = 1'b0;
    if (frozen) begin
      freeze_pc    = 1'b1;
      freeze_IF_ID = 1'b1;
      freeze_back  = 1'b1;
    end else if (branch_taken) begin
      flush_IF_ID   = 1'b1;
      bubble_ID_EXE = 1'b1;
    end else if (hazard) begin
      freeze_pc     = 1'b1;
      freeze_IF_ID  = 1'b1;
      bubble_ID_EXE = 1'b1;
    end
  end

  // Sequencer state, wait counter, forwarding-mode register and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      fwd_enable  <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          wait_cnt <= '0;
          if (mem_req && !mem_ready) begin
            state <= ST_MEM_WAIT;
          end
          // Safe point: nothing in flight that depends on the current mode.
          if (!mem_busy && !branch_taken && !hazard) begin
            fwd_enable <= fwd_mode_req;
          end
        end
        ST_MEM_WAIT: begin
          if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
          if (mem_ready) begin
            state <= ST_RUN;
          end else if (wait_expired) begin
            state       <= ST_ERR;
            mem_timeout <= 1'b1;
          end
        end
        ST_ERR: begin
          state <= ST_ERR;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

`ifdef PERF_CNT_EN
  // Cycle counters, one per active-priority class; they wrap at 2**32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles   <= '0;
      flush_cycles   <= '0;
      memwait_cycles <= '0;
    end else begin
      if (mem_busy) begin
        memwait_cycles <= memwait_cycles + 32'd1;
      end
      if (!frozen && branch_taken) begin
        flush_cycles <= flush_cycles + 32'd1;
      end
      if (!frozen && !branch_taken && hazard) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: table-driven single-cycle vectors plus
// hand-written multi-cycle sequences, checked through an expectation queue.
// Expected bits are ordered {freeze_pc, freeze_IF_ID, bubble_ID_EXE,
// flush_IF_ID, freeze_back, fwd_enable, mem_timeout}.
module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       fwd_mode_req;
  logic [3:0] src_1;
  logic [3:0] src_2;
  logic       two_src;
  logic [3:0] EXE_dest;
  logic       EXE_wb_en;
  logic       EXE_mem_read;
  logic [3:0] MEM_dest;
  logic       MEM_wb_en;
  logic       branch_taken;
  logic       mem_req;
  logic       mem_ready;
  logic       freeze_pc;
  logic       freeze_IF_ID;
  logic       bubble_ID_EXE;
  logic       flush_IF_ID;
  logic       freeze_back;
  logic       fwd_enable;
  logic       mem_timeout;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(3), .CNT_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .fwd_mode_req (fwd_mode_req),
    .src_1        (src_1),
    .src_2        (src_2),
    .two_src      (two_src),
    .EXE_dest     (EXE_dest),
    .EXE_wb_en    (EXE_wb_en),
    .EXE_mem_read (EXE_mem_read),
    .MEM_dest     (MEM_dest),
    .MEM_wb_en    (MEM_wb_en),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .freeze_pc    (freeze_pc),
    .freeze_IF_ID (freeze_IF_ID),
    .bubble_ID_EXE(bubble_ID_EXE),
    .flush_IF_ID  (flush_IF_ID),
    .freeze_back  (freeze_back),
    .fwd_enable   (fwd_enable),
    .mem_timeout  (mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       fwd;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       two;
    logic [3:0] ed;
    logic       ew;
    logic       er;
    logic [3:0] md;
    logic       mw;
    logic       br;
    logic       mreq;
    logic       mrdy;
  } in_t;

  typedef struct {
    in_t        in;
    logic [6:0] exp;
    string      name;
  } vec_t;

  typedef struct {
    logic [6:0] exp;
    string      name;
  } sb_t;

  localparam logic [6:0] IDLE  = 7'b0000000;
  localparam logic [6:0] FRZ   = 7'b1100100;
  localparam logic [6:0] FLUSH = 7'b0011000;
  localparam logic [6:0] ERRV  = 7'b1100101;

  sb_t  sb_q[$];
  int   total;
  int   bad;
  int   fb_cnt;
  vec_t tbl[15];

  function automatic in_t mk(input logic fwd, input logic [3:0] s1, input logic [3:0] s2,
                             input logic two, input logic [3:0] ed, input logic ew,
                             input logic er, input logic [3:0] md, input logic mw,
                             input logic br, input logic mreq, input logic mrdy);
    in_t r;
    r.fwd = fwd; r.s1 = s1; r.s2 = s2; r.two = two; r.ed = ed; r.ew = ew;
    r.er = er; r.md = md; r.mw = mw; r.br = br; r.mreq = mreq; r.mrdy = mrdy;
    return r;
  endfunction

  function automatic in_t mem(input logic mreq, input logic mrdy, input logic br);
    return mk(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, br, mreq, mrdy);
  endfunction

  task automatic drive(input in_t v);
    fwd_mode_req = v.fwd;
    src_1        = v.s1;
    src_2        = v.s2;
    two_src      = v.two;
    EXE_dest     = v.ed;
    EXE_wb_en    = v.ew;
    EXE_mem_read = v.er;
    MEM_dest     = v.md;
    MEM_wb_en    = v.mw;
    branch_taken = v.br;
    mem_req      = v.mreq;
    mem_ready    = v.mrdy;
  endtask

  // One cycle: drive just after the rising edge, check on the falling edge.
  task automatic step(input in_t v, input logic [6:0] exp, input string name);
    sb_t e;
    sb_t got;
    logic [6:0] act;
    drive(v);
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
    @(negedge clk);
    act = {freeze_pc, freeze_IF_ID, bubble_ID_EXE, flush_IF_ID, freeze_back,
           fwd_enable, mem_timeout};
    if (freeze_back) fb_cnt++;
    got = sb_q.pop_front();
    total++;
    if (act !== got.exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", got.name, act, got.exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(mem(1'b0, 1'b0, 1'b0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_int(input int act, input int exp, input string name);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    fb_cnt = 0;

    //                fwd s1 s2 two ed ew er md mw br rq rdy
    tbl[0]  = '{mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 7'b0000000, "fwd_req_idle"};
    tbl[1]  = '{mk(1, 3, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0), 7'b1110010, "load_use_stall"};
    tbl[2]  = '{mk(1, 3, 0, 0, 3, 0, 0, 3, 1, 0, 0, 0), 7'b0000010, "load_use_one_cycle"};
    tbl[3]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 7'b0000010, "fwd_off_req"};
    tbl[4]  = '{mk(0, 1, 5, 1, 0, 0, 0, 5, 1, 0, 0, 0), 7'b1110000, "mem_src2_stall"};
    tbl[5]  = '{mk(0, 1, 5, 0, 0, 0, 0, 5, 1, 0, 0, 0), 7'b0000000, "mem_src2_ignored"};
    tbl[6]  = '{mk(0, 7, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0), 7'b1110000, "exe_alu_stall"};
    tbl[7]  = '{mk(1, 7, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0), 7'b1110000, "fwd_toggle_in_stall"};
    tbl[8]  = '{mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 7'b0000000, "fwd_load_point"};
    tbl[9]  = '{mk(1, 7, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0), 7'b0000010, "fwd_alu_no_stall"};
    tbl[10] = '{mk(0, 3, 0, 0, 3, 1, 1, 0, 0, 1, 0, 0), 7'b0011010, "branch_over_hazard"};
    tbl[11] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 7'b0000010, "fwd_held_on_branch"};
    tbl[12] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 7'b0000000, "fwd_cleared"};
    tbl[13] = '{mk(0, 4, 2, 1, 2, 1, 0, 4, 1, 0, 0, 0), 7'b1110000, "dual_hit_stall"};
    tbl[14] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 7'b0000000, "table_end"};

    rst = 1'b1;
    drive(mem(1'b0, 1'b0, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step(mem(1'b0, 1'b0, 1'b0), IDLE, "reset_state");

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].in, tbl[i].exp, tbl[i].name);
    end

    // Memory completes four cycles into the access.
    fb_cnt = 0;
    step(mem(1'b1, 1'b0, 1'b0), FRZ, "memlate_req");
    step(mem(1'b0, 1'b0, 1'b0), FRZ, "memlate_w1");
    step(mem(1'b0, 1'b0, 1'b0), FRZ, "memlate_w2");
    step(mem(1'b0, 1'b1, 1'b0), FRZ, "memlate_ready");
    step(mem(1'b0, 1'b0, 1'b0), IDLE, "memlate_run");
    check_int(fb_cnt, 4, "memlate_freeze_count");

    // Same-cycle completion: no freeze at all.
    step(mem(1'b1, 1'b1, 1'b0), IDLE, "memzero_req");
    step(mem(1'b0, 1'b0, 1'b0), IDLE, "memzero_after");

    // Branch held during a memory wait is flushed only once unfrozen.
    step(mem(1'b1, 1'b0, 1'b1), FRZ, "br_wait_req");
    step(mem(1'b0, 1'b0, 1'b1), FRZ, "br_wait_w1");
    step(mem(1'b0, 1'b1, 1'b1), FRZ, "br_wait_ready");
    step(mem(1'b0, 1'b0, 1'b1), FLUSH, "br_after_wait");
    step(mem(1'b0, 1'b0, 1'b0), IDLE, "br_after_idle");

    // New request on the return-to-RUN cycle re-enters the wait.
    step(mem(1'b1, 1'b0, 1'b0), FRZ, "reenter_req");
    step(mem(1'b0, 1'b1, 1'b0), FRZ, "reenter_ready");
    step(mem(1'b1, 1'b0, 1'b0), FRZ, "reenter_run");
    step(mem(1'b0, 1'b0, 1'b0), FRZ, "reenter_wait");
    step(mem(1'b0, 1'b1, 1'b0), FRZ, "reenter_ready2");
    step(mem(1'b0, 1'b0, 1'b0), IDLE, "reenter_idle");

    // Reset in the middle of a wait returns to RUN with a clean counter.
    step(mem(1'b1, 1'b0, 1'b0), FRZ, "rstwait_req");
    step(mem(1'b0, 1'b0, 1'b0), FRZ, "rstwait_w1");
    do_reset();
    step(mem(1'b0, 1'b0, 1'b0), IDLE, "rstwait_run");
    step(mem(1'b1, 1'b0, 1'b0), FRZ, "cnt_req");
    step(mem(1'b0, 1'b0, 1'b0), FRZ, "cnt_w0");
    step(mem(1'b0, 1'b0, 1'b0), FRZ, "cnt_w1");
    step(mem(1'b0, 1'b0, 1'b0), FRZ, "cnt_w2");
    step(mem(1'b0, 1'b1, 1'b0), FRZ, "cnt_w3_ready");
    step(mem(1'b0, 1'b0, 1'b0), IDLE, "cnt_no_err");

    // Timeout: four wait cycles tolerated, then sticky ERR until reset.
    step(mem(1'b1, 1'b0, 1'b0), FRZ, "to_req");
    step(mem(1'b0, 1'b0, 1'b0), FRZ, "to_w0");
    step(mem(1'b0, 1'b0, 1'b0), FRZ, "to_w1");
    step(mem(1'b0, 1'b0, 1'b0), FRZ, "to_w2");
    step(mem(1'b0, 1'b0, 1'b0), FRZ, "to_w3");
    step(mem(1'b0, 1'b0, 1'b0), ERRV, "err_entry");
    step(mem(1'b0, 1'b1, 1'b0), ERRV, "err_sticky_ready");
    step(mem(1'b0, 1'b0, 1'b1), ERRV, "err_no_flush");
    do_reset();
    step(mem(1'b0, 1'b0, 1'b0), IDLE, "err_cleared");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
